// File: rtl/vt_encoder.sv
// ---------------------------------------------------------------------------
// vt_encoder
//
// Sequential Varshamov-Tenengolts encoder.  K information bits are scattered
// over the non-power-of-two positions of an n-bit word.  The weighted checksum
// sum(i*x_i) mod (n+1) is then accumulated one position per clock.  Finally the
// M parity bits at positions 1,2,4,...,2^(M-1) are chosen so that the completed
// codeword has syndrome a.
//
// The codeword is presented in strand format: bit (i-1) of the bus carries x_i,
// and every bit above n-1 is zero.  This lets the output feed the channel model
// or the IDS decoder directly.
//
// Timing:  E0 accepts start.  E1..En each fold one position into the checksum.
// En+1 writes the parity and the codeword and raises done.  For n=10, done
// therefore rises 11 edges after the accepting edge.
// ---------------------------------------------------------------------------
module vt_encoder #(
  parameter int DATA_WIDTH = 32,
  parameter int n          = 10,
  parameter int a          = 0,
  localparam int M         = $clog2(n + 1),
  localparam int K         = n - M
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [K-1:0]          info,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] codeword
);

  // Constants, sized to match the accumulator arithmetic.  The accumulator
  // always holds a value in 0..n, so M bits are enough.  The one-bit-wider
  // values cover the intermediate sums.
  localparam logic [M-1:0] N_V   = M'(n);
  localparam logic [M:0]   NP1_V = (M + 1)'(n + 1);
  localparam logic [M:0]   A_V   = (M + 1)'(a);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_PARITY,
    S_DONE
  } state_t;

  state_t                  r_state;
  logic [n-1:0]            r_work;
  logic [M-1:0]            r_acc;
  logic [M-1:0]            r_pos;
  logic                    r_busy;
  logic                    r_done;
  logic [DATA_WIDTH-1:0]   r_codeword;

  logic [n-1:0]            w_mapped;
  logic                    w_curBit;
  logic [M:0]              w_accSum;
  logic [M-1:0]            w_accNext;
  logic [M-1:0]            w_syn;
  logic [n-1:0]            w_final;

  // Returns the (j+1)-th position in 1..n that is not a power of two.
  // Information bit j lands at that position.  The function is only called
  // with constant arguments inside an unrolled loop, so it reduces to wiring.
  function automatic int infoPos(input int j);
    int cnt;
    int res;
    cnt = 0;
    res = 1;
    for (int p = 1; p <= n; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == j) begin
          res = p;
        end
        cnt = cnt + 1;
      end
    end
    return res;
  endfunction

  // Scatter the information bits into their data positions.  The parity
  // positions stay zero so that they add nothing to the running checksum.
  always_comb begin
    w_mapped = '0;
    for (int j = 0; j < K; j++) begin
      w_mapped[infoPos(j) - 1] = info[j];
    end
  end

  // Select x_pos from the work register.  This is a plain mux over the n
  // positions, so that r_pos may use a width that does not match clog2(n).
  always_comb begin
    w_curBit = 1'b0;
    for (int i = 1; i <= n; i++) begin
      if (r_pos == M'(i)) begin
        w_curBit = r_work[i - 1];
      end
    end
  end

  // One checksum step: add pos when x_pos is set, then reduce modulo n+1.
  // Both operands are at most n, so a single conditional subtract is enough.
  always_comb begin
    w_accSum  = {1'b0, r_acc} + (w_curBit ? {1'b0, r_pos} : {(M + 1){1'b0}});
    w_accNext = (w_accSum >= NP1_V) ? M'(w_accSum - NP1_V) : M'(w_accSum);
  end

  // Parity value d = (a - acc) mod (n+1).  Adding n+1 first keeps the
  // difference non-negative when acc exceeds a.  The result is at most n,
  // so it fits in the M parity bits.
  always_comb begin
    if ({1'b0, r_acc} > A_V) begin
      w_syn = M'(A_V + NP1_V - {1'b0, r_acc});
    end else begin
      w_syn = M'(A_V - {1'b0, r_acc});
    end
  end

  // Build the finished codeword: the work register with bit j of d written
  // into power-of-two position 2^j.
  always_comb begin
    w_final = r_work;
    for (int j = 0; j < M; j++) begin
      w_final[(1 << j) - 1] = w_syn[j];
    end
  end

  // Encoder state machine.  busy, done and codeword are all registered here.
  // A start during ACCUM or PARITY is ignored.  A start during DONE begins a
  // new encode, and the previous codeword stays visible until that encode
  // reaches PARITY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_work     <= '0;
      r_acc      <= '0;
      r_pos      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_codeword <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_work  <= w_mapped;
            r_acc   <= '0;
            r_pos   <= M'(1);
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          r_acc <= w_accNext;
          if (r_pos == N_V) begin
            r_pos   <= '0;
            r_state <= S_PARITY;
          end else begin
            r_pos <= r_pos + M'(1);
          end
        end
        S_PARITY: begin
          r_codeword <= DATA_WIDTH'(w_final);
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign codeword = r_codeword;

endmodule

// File: doc/vt_encoder.md
Name: vt_encoder

Overview:
- Sequential Varshamov-Tenengolts (VT) encoder: the transmit-side counterpart of the soft forward/backward IDS decoder.
- Maps K information bits into an n-bit codeword x_1..x_n satisfying sum(i*x_i) ≡ a (mod n+1).
- Output uses the same DATA_WIDTH strand format the decoder consumes, so the codeword can drive the channel model / decoder directly.
- Parity is placed at power-of-two positions; the weighted checksum is accumulated one position per cycle.

Parameters:
- DATA_WIDTH, 32, width of the codeword output bus (strand format); requires n <= DATA_WIDTH
- n, 10, codeword length (pre-IDS length)
- a, 0, VT syndrome; requires 0 <= a <= n
- M (localparam), $clog2(n+1), number of parity bits (positions 1,2,4,...,2^(M-1))
- K (localparam), n-M, number of information bits

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request; accepted only in IDLE or DONE
- info  in  K  information bits, sampled on the accepting edge
- busy  out  1  high while an encode is in progress
- done  out  1  level; high from encode completion until the next accepted start
- codeword  out  DATA_WIDTH  bit (i-1) = x_i for i=1..n; bits n..DATA_WIDTH-1 always 0

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0; done=0; codeword=0; internal work register, accumulator and position counter all 0.
- Info mapping: info[j] goes to the (j+1)-th non-power-of-two position in ascending order. For n=10: info[0..5] -> positions 3,5,6,7,9,10. Parity positions are initially 0.
- States: IDLE, ACCUM, PARITY, DONE.
- IDLE/DONE with start=1 (edge E0):
  - latch the mapped info into the work register; acc=0; pos=1; busy=1; done=0; go to ACCUM.
- ACCUM (edges E1..En), one position per edge:
  - acc <= (acc + (work[pos] ? pos : 0)) mod (n+1).
  - Modulo is a single conditional subtract of n+1; acc is always in 0..n.
  - pos increments; at pos==n go to PARITY.
  - Parity positions are 0 in work, so they contribute nothing.
- PARITY (edge En+1):
  - d = (a - acc) mod (n+1), computed as a - acc, plus (n+1) if negative.
  - For j=0..M-1: x at position 2^j = d[j]. Since d <= n <= 2^M - 1, this is always representable.
  - codeword <= completed work register, zero-padded; done=1; busy=0; go to DONE.
- Latency: done rises on the (n+1)-th edge after the accepting edge E0 (11 cycles for n=10).
- Output stability: codeword is updated only in PARITY and holds its previous value during busy.
- start while busy: ignored, with no effect on the in-flight encode.
- start in DONE: accepted; done drops on the next edge and codeword keeps the old value until the new PARITY.
- info changes after E0: no effect.
- rst_n asserted mid-encode: immediate abort to the reset values above. No done pulse; the encode is lost.
- Invariant: every codeword output with done=1 satisfies sum(i*x_i) mod (n+1) == a.

Test Plan:
- Reset, n=10, a=0: release rst_n, pulse start with info=6'b000000 -> busy=1 for 11 cycles; done=1 on the 11th edge; codeword=0x000.
- a=0, info=6'b000001 -> x3=1, acc=3, d=8 -> codeword=0x084 (bits 2 and 7).
- a=0, info=6'b111111 -> acc=40 mod 11=7, d=4 -> codeword=0x37C.
- a=0, info=6'b100000 -> acc=10, d=1 -> codeword=0x201.
- Second module instance with a=5, info=0 -> d=5 -> codeword=0x009.
- Pulse start again at cycle 4 while busy -> ignored; original result and timing unchanged.
- Assert rst_n=0 at cycle 6 of an encode -> outputs 0 immediately; a fresh start afterwards encodes correctly.
- Random sweep of all 64 info values for each a in 0..10 -> checksum invariant holds; info bits recovered unchanged from their non-power-of-two positions.
